// File: rtl/srm_pkg.sv
// Shared constants, FSM states and datapath control bundle for the SRM controller.
`timescale 1ns/1ps
package srm_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_W  = 3;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;
  localparam logic [1:0] OP_MEM     = 2'b00;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_C      = 2'b00;
  localparam logic [1:0] VSEL_PC     = 2'b01;
  localparam logic [1:0] VSEL_SXIMM8 = 2'b10;
  localparam logic [1:0] VSEL_MDATA  = 2'b11;

  typedef enum logic [3:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_EXEC, S_WB,
    S_ADDR, S_MEM_RD, S_LD_WB, S_ST_B, S_MEM_WR, S_HALT
  } state_e;

  // Per-cycle datapath/memory control produced by the FSM.
  typedef struct packed {
    logic [1:0]        mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [REG_W-1:0]  anum;
    logic [REG_W-1:0]  bnum;
    logic [REG_W-1:0]  writenum;
    logic [1:0]        vsel;
    logic [1:0]        shift;
    logic [1:0]        aluop;
    logic              asel;
    logic              bsel;
    logic              loadc;
    logic              loads;
    logic              write;
  } dp_ctrl_t;

endpackage

// File: rtl/srm_decoder.sv
// Instruction field extraction and immediate sign extension (purely combinational).
`timescale 1ns/1ps
module srm_decoder
  import srm_pkg::*;
(
  input  logic [WORD_W-1:0] ir,
  output logic [2:0]        opcode_c,
  output logic [1:0]        op_c,
  output logic [REG_W-1:0]  rn_c,
  output logic [REG_W-1:0]  rd_c,
  output logic [1:0]        sh_c,
  output logic [REG_W-1:0]  rm_c,
  output logic [WORD_W-1:0] sximm5_c,
  output logic [WORD_W-1:0] sximm8_c
);

  assign opcode_c = ir[15:13];
  assign op_c     = ir[12:11];
  assign rn_c     = ir[10:8];
  assign rd_c     = ir[7:5];
  assign sh_c     = ir[4:3];
  assign rm_c     = ir[2:0];
  assign sximm5_c = {{(WORD_W-5){ir[4]}}, ir[4:0]};
  assign sximm8_c = {{(WORD_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/srm_controller.sv
// Multi-cycle SRM CPU controller: fetch/decode FSM, PC, IR and data address registers.
// Optional HALT instruction (opcode 111) enabled by defining SRM_HALT_EN.
`timescale 1ns/1ps
module srm_controller
  import srm_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] read_data,
  input  logic [15:0] creg,
  output logic [1:0]  mem_cmd,
  output logic [7:0]  mem_addr,
  output logic [2:0]  anum,
  output logic [2:0]  bnum,
  output logic [2:0]  writenum,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [7:0]  PC,
  output logic        halted
);

  state_e              state, state_nx;
  logic [ADDR_W-1:0]   pc_q;
  logic [WORD_W-1:0]   ir_q;
  logic [ADDR_W-1:0]   data_addr_q;
  dp_ctrl_t            ctrl;

  logic [2:0]          opcode;
  logic [1:0]          op;
  logic [REG_W-1:0]    rn, rd, rm;
  logic [1:0]          sh;

  // Only the low byte of the ALU result is ever used as an address.
  logic                unused_creg_hi;
  assign unused_creg_hi = ^creg[WORD_W-1:ADDR_W];

  srm_decoder u_dec (
    .ir       (ir_q),
    .opcode_c (opcode),
    .op_c     (op),
    .rn_c     (rn),
    .rd_c     (rd),
    .sh_c     (sh),
    .rm_c     (rm),
    .sximm5_c (sximm5),
    .sximm8_c (sximm8)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nx;
  end

  // Architectural registers, each updated in exactly one FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      data_addr_q <= '0;
    end else begin
      if (state == S_UPD_PC) pc_q        <= pc_q + ADDR_W'(1);
      if (state == S_IF2)    ir_q        <= read_data;
      if (state == S_ADDR)   data_addr_q <= creg[ADDR_W-1:0];
    end
  end

`ifdef SRM_HALT_EN
  logic halted_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= (state_nx == S_HALT);
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_comb begin
    state_nx      = state;
    ctrl          = '0;
    ctrl.mem_cmd  = MEM_NONE;
    ctrl.mem_addr = pc_q;
    ctrl.vsel     = VSEL_C;
    case (state)
      S_RST:    state_nx = S_IF1;
      S_IF1: begin
        ctrl.mem_cmd = MEM_READ;
        state_nx     = S_IF2;
      end
      S_IF2: begin
        ctrl.mem_cmd = MEM_READ;
        state_nx     = S_UPD_PC;
      end
      S_UPD_PC: state_nx = S_DECODE;
      S_DECODE: begin
        // Anything not matched below falls back to fetch as a NOP.
        state_nx = S_IF1;
        if (opcode == OPC_MOV && op == OP_MOV_IMM)      state_nx = S_WR_IMM;
        else if (opcode == OPC_MOV && op == OP_MOV_REG) state_nx = S_EXEC;
        else if (opcode == OPC_ALU)                     state_nx = S_EXEC;
        else if (opcode == OPC_LDR && op == OP_MEM)     state_nx = S_ADDR;
        else if (opcode == OPC_STR && op == OP_MEM)     state_nx = S_ADDR;
`ifdef SRM_HALT_EN
        else if (opcode == OPC_HALT)                    state_nx = S_HALT;
`endif
      end
      S_WR_IMM: begin
        ctrl.writenum = rn;
        ctrl.vsel     = VSEL_SXIMM8;
        ctrl.write    = 1'b1;
        state_nx      = S_IF1;
      end
      S_EXEC: begin
        ctrl.bnum  = rm;
        ctrl.shift = sh;
        state_nx   = S_WB;
        if (opcode == OPC_MOV) begin
          ctrl.asel  = 1'b1;
          ctrl.aluop = OP_ADD;
          ctrl.loadc = 1'b1;
        end else begin
          ctrl.anum  = rn;
          ctrl.aluop = op;
          if (op == OP_CMP) begin
            ctrl.loads = 1'b1;
            state_nx   = S_IF1;
          end else begin
            ctrl.loadc = 1'b1;
          end
        end
      end
      S_WB: begin
        ctrl.writenum = rd;
        ctrl.vsel     = VSEL_C;
        ctrl.write    = 1'b1;
        state_nx      = S_IF1;
      end
      S_ADDR: begin
        ctrl.anum  = rn;
        ctrl.bsel  = 1'b1;
        ctrl.aluop = OP_ADD;
        ctrl.loadc = 1'b1;
        state_nx   = (opcode == OPC_LDR) ? S_MEM_RD : S_ST_B;
      end
      S_MEM_RD: begin
        ctrl.mem_cmd  = MEM_READ;
        ctrl.mem_addr = data_addr_q;
        state_nx      = S_LD_WB;
      end
      S_LD_WB: begin
        ctrl.mem_cmd  = MEM_READ;
        ctrl.mem_addr = data_addr_q;
        ctrl.writenum = rd;
        ctrl.vsel     = VSEL_MDATA;
        ctrl.write    = 1'b1;
        state_nx      = S_IF1;
      end
      S_ST_B: begin
        ctrl.bnum  = rd;
        ctrl.asel  = 1'b1;
        ctrl.loadc = 1'b1;
        state_nx   = S_MEM_WR;
      end
      S_MEM_WR: begin
        ctrl.mem_cmd  = MEM_WRITE;
        ctrl.mem_addr = data_addr_q;
        state_nx      = S_IF1;
      end
      S_HALT:   state_nx = S_HALT;
      default:  state_nx = S_RST;
    endcase
  end

  assign mem_cmd  = ctrl.mem_cmd;
  assign mem_addr = ctrl.mem_addr;
  assign anum     = ctrl.anum;
  assign bnum     = ctrl.bnum;
  assign writenum = ctrl.writenum;
  assign vsel     = ctrl.vsel;
  assign shift    = ctrl.shift;
  assign ALUop    = ctrl.aluop;
  assign asel     = ctrl.asel;
  assign bsel     = ctrl.bsel;
  assign loadc    = ctrl.loadc;
  assign loads    = ctrl.loads;
  assign write    = ctrl.write;
  assign PC       = pc_q;

endmodule

// File: tb/tb_srm_controller.sv
// Scoreboard bench for srm_controller: an instruction-level model queues the expected
// per-cycle outputs, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_srm_controller;

`ifdef SRM_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]  mem_cmd;
    logic [7:0]  mem_addr;
    logic [2:0]  anum;
    logic [2:0]  bnum;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic        write;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [7:0]  pc;
    logic        halted;
  } rec_t;

  logic        clk, rst_n;
  logic [15:0] read_data, creg;
  logic [1:0]  mem_cmd;
  logic [7:0]  mem_addr;
  logic [2:0]  anum, bnum, writenum;
  logic [1:0]  vsel, shift, ALUop;
  logic        asel, bsel, loadc, loads, write;
  logic [15:0] sximm5, sximm8;
  logic [7:0]  PC;
  logic        halted;

  srm_controller #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .read_data(read_data), .creg(creg),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .anum(anum), .bnum(bnum),
    .writenum(writenum), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .write(write),
    .sximm5(sximm5), .sximm8(sximm8), .PC(PC), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memory: data appears the cycle after the address.
  logic [15:0] mem [256];
  logic [7:0]  addr_q = 8'h00;
  always @(posedge clk) addr_q <= mem_addr;
  assign read_data = mem[addr_q];

  int          n_tests = 0;
  int          n_fail  = 0;
  rec_t        exp_q[$];
  logic [15:0] creg_seq [4096];
  bit          mon_en = 1'b0;
  int          mon_cyc = 0;

  // Reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_halted;
  int          m_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sext(input int v, input int bits);
    int s;
    s = v;
    if (s >= (1 << (bits - 1))) s = s - (1 << bits);
    return 16'(s);
  endfunction

  function automatic rec_t dflt();
    rec_t r;
    r          = '0;
    r.mem_addr = m_pc;
    r.pc       = m_pc;
    r.sximm5   = sext(int'(m_ir[4:0]), 5);
    r.sximm8   = sext(int'(m_ir[7:0]), 8);
    r.halted   = m_halted;
    return r;
  endfunction

  task automatic push(input rec_t r);
    exp_q.push_back(r);
    m_cyc++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_pc = 8'h00; m_ir = 16'h0000; m_halted = 1'b0; m_cyc = 0;
  endtask

  // Expected cycle-by-cycle outputs for one instruction, from the ISA cycle table.
  task automatic model_instr(input logic [15:0] ir);
    rec_t r;
    int opc, op, rn, rd, sh, rm;
    logic [7:0] da;
    r = dflt(); r.mem_cmd = 2'b01; push(r);
    r = dflt(); r.mem_cmd = 2'b01; push(r);
    m_ir = ir;
    push(dflt());
    m_pc = m_pc + 8'd1;
    push(dflt());
    opc = int'(ir[15:13]); op = int'(ir[12:11]); rn = int'(ir[10:8]);
    rd = int'(ir[7:5]); sh = int'(ir[4:3]); rm = int'(ir[2:0]);
    if (opc == 6 && op == 2) begin
      r = dflt(); r.writenum = 3'(rn); r.vsel = 2'd2; r.write = 1'b1; push(r);
    end else if ((opc == 6 && op == 0) || opc == 5) begin
      r = dflt(); r.bnum = 3'(rm); r.shift = 2'(sh);
      if (opc == 6) r.asel = 1'b1;
      else begin r.anum = 3'(rn); r.aluop = 2'(op); end
      if (opc == 5 && op == 1) r.loads = 1'b1;
      else r.loadc = 1'b1;
      push(r);
      if (!(opc == 5 && op == 1)) begin
        r = dflt(); r.writenum = 3'(rd); r.write = 1'b1; push(r);
      end
    end else if ((opc == 3 || opc == 4) && op == 0) begin
      da = creg_seq[m_cyc][7:0];
      r = dflt(); r.anum = 3'(rn); r.bsel = 1'b1; r.loadc = 1'b1; push(r);
      if (opc == 3) begin
        r = dflt(); r.mem_cmd = 2'b01; r.mem_addr = da; push(r);
        r.writenum = 3'(rd); r.vsel = 2'd3; r.write = 1'b1; push(r);
      end else begin
        r = dflt(); r.bnum = 3'(rd); r.asel = 1'b1; r.loadc = 1'b1; push(r);
        r = dflt(); r.mem_cmd = 2'b10; r.mem_addr = da; push(r);
      end
    end else if (opc == 7 && HALT_EN) begin
      m_halted = 1'b1;
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [4:0]  u;
    w = 16'($urandom);
    case ($urandom_range(0, 9))
      0: w[15:11] = 5'b11010;
      1: w[15:11] = 5'b11000;
      2: w[15:11] = 5'b10100;
      3: w[15:11] = 5'b10101;
      4: w[15:11] = 5'b10110;
      5: w[15:11] = 5'b10111;
      6: w[15:11] = 5'b01100;
      7: w[15:11] = 5'b10000;
      8: begin
        case ($urandom_range(0, 3))
          0: u = 5'b00000;
          1: u = 5'b11001;
          2: u = 5'b01101;
          default: u = 5'b10011;
        endcase
        w[15:11] = u;
      end
      default: begin
        u = {3'b111, 2'($urandom)};
        if (HALT_EN) u = 5'b10100;
        w[15:11] = u;
      end
    endcase
    return w;
  endfunction

  // Drive creg per cycle while the monitor checks; caller sits just after a posedge.
  task automatic run_cycles(input int n);
    mon_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      creg = creg_seq[i];
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
  endtask

  always @(negedge clk) begin
    rec_t act, expv;
    if (mon_en) begin
      act = '{mem_cmd: mem_cmd, mem_addr: mem_addr, anum: anum, bnum: bnum,
              writenum: writenum, vsel: vsel, shift: shift, aluop: ALUop,
              asel: asel, bsel: bsel, loadc: loadc, loads: loads, write: write,
              sximm5: sximm5, sximm8: sximm8, pc: PC, halted: halted};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL cycle %0d scoreboard: actual output %h required none", mon_cyc, act);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_fail++;
          $display("FAIL cycle %0d outputs: actual %h required %h", mon_cyc, act, expv);
        end
      end
      if (write && mem_cmd == 2'b10) begin
        n_fail++;
        $display("FAIL cycle %0d write_vs_memwrite: actual both required exclusive", mon_cyc);
      end
      mon_cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "timeout");
  end

  logic [15:0] prog [8];
  rec_t        wr_exp;
  int          n;

  initial begin
    rst_n = 1'b0;
    creg  = 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] = rand_instr();
    for (int i = 0; i < 4096; i++) creg_seq[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("rst_pc", 32'(PC), 32'h00);
    chk("rst_mem_addr", 32'(mem_addr), 32'h00);
    chk("rst_strobes", 32'({write, loadc, loads}), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_imm", 32'({sximm8, sximm5}), 32'h0);

    // Phase 1: random program, long enough for the PC to wrap FF -> 00
    model_reset();
    for (int i = 0; i < 300; i++) model_instr(mem[m_pc]);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n = exp_q.size();
    run_cycles(n);
    chk("phase1_drain", 32'(exp_q.size()), 32'h0);

    // Phase 2: STR interrupted by reset in its memory-write cycle
    @(negedge clk); rst_n = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h8140;
    model_reset();
    model_instr(16'h8140);
    wr_exp = exp_q.pop_back();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycles(exp_q.size());
    #2;
    chk("str_memwr_cmd", 32'(mem_cmd), 32'h2);
    chk("str_memwr_addr", 32'(mem_addr), 32'(wr_exp.mem_addr));
    chk("str_pc_before_rst", 32'(PC), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mem_cmd", 32'(mem_cmd), 32'h0);
    chk("async_rst_pc", 32'(PC), 32'h00);
    chk("async_rst_mem_addr", 32'(mem_addr), 32'h00);
    chk("async_rst_write", 32'({write, loadc}), 32'h0);

    // Phase 3: directed MOV/ADD/LDR/CMP/111 sequence fetched from 00 after reset
    prog[0] = 16'hD105; prog[1] = 16'hA0A1; prog[2] = 16'h6143; prog[3] = 16'hA908;
    prog[4] = 16'hE000; prog[5] = 16'hD207; prog[6] = 16'h0000; prog[7] = 16'hC0F8;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    for (int i = 0; i < 4096; i++) creg_seq[i] = 16'h0008;
    model_reset();
    for (int i = 0; i < 8; i++) if (!m_halted) model_instr(prog[i]);
    if (m_halted) for (int i = 0; i < 10; i++) push(dflt());
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_cycles(exp_q.size());
    chk("phase3_drain", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/srm_controller.md
SRM_CONTROLLER -- requirements
Module: srm_controller
Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, meaning PC value loaded on reset.
REQ-002 SHALL have port clk  in  1  rising-edge clock, sole clock.
REQ-003 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port read_data  in  16  memory read data, valid one cycle after READ address presented.
REQ-005 SHALL have port creg  in  16  datapath ALU result (combinational C-register input).
REQ-006 SHALL have ports mem_cmd  out  2  (NONE 00, READ 01, WRITE 10); mem_addr  out  8.
REQ-007 SHALL have ports anum, bnum, writenum  out  3 each: register selects.
REQ-008 SHALL have ports vsel, shift, ALUop  out  2 each; asel, bsel, loadc, loads, write  out  1 each.
REQ-009 SHALL have ports sximm5, sximm8  out  16; PC  out  8; halted  out  1.
Function
REQ-010 SHALL decode IR fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0], imm5[4:0]; sximm5/sximm8 sign-extended from IR.
REQ-011 SHALL drive defaults in every state unless stated: strobes 0, mem_cmd NONE, mem_addr PC, asel/bsel 0, vsel 00, shift 00, ALUop 00, selects 0.
REQ-012 SHALL run FSM RST->IF1->IF2->UPD_PC->DECODE, then per instruction, back to IF1.
REQ-013 IF1: mem_cmd READ, mem_addr PC; IF2: mem_cmd READ, IR<=read_data at edge.
REQ-014 UPD_PC: PC<=PC+1 mod 256 (FF wraps to 00).
REQ-015 MOV Rn,#imm8 (110/10): WR_IMM writenum=Rn, vsel=10, write=1.
REQ-016 MOV Rd,Rm (110/00): EXEC bnum=Rm, asel=1, shift=sh, ALUop=00, loadc=1; WB writenum=Rd, vsel=00, write=1.
REQ-017 ADD/AND/MVN (101/00,10,11): EXEC anum=Rn, bnum=Rm, shift=sh, ALUop=op, loadc=1; then WB as REQ-016.
REQ-018 CMP (101/01): EXEC with loads=1, loadc=0; no WB.
REQ-019 LDR (011/00): ADDR anum=Rn, bsel=1, ALUop=00, loadc=1, data_addr<=creg[7:0]; MEM_RD mem_cmd READ, mem_addr data_addr; LD_WB same mem outputs, writenum=Rd, vsel=11, write=1.
REQ-020 STR (100/00): ADDR as REQ-019; ST_B bnum=Rd, asel=1, loadc=1; MEM_WR mem_cmd WRITE, mem_addr data_addr.
REQ-021 Cycles IF1-to-next-IF1: MOV imm 5, MOV reg/ALU 6, CMP 5, LDR 7, STR 7.
REQ-022 Undefined opcode/op combinations SHALL be NOPs: DECODE->IF1, no strobe asserted.
REQ-023 write and mem_cmd WRITE SHALL never be asserted in the same cycle.
Reset
REQ-024 rst_n low SHALL immediately force state RST, PC=RESET_PC, IR=0, data_addr=0, halted=0, all strobes 0, mem_cmd NONE, regardless of current state.
REQ-025 First rising clk edge with rst_n high SHALL move RST->IF1.
Configuration
REQ-026 Macro SRM_HALT_EN defined: opcode 111 SHALL enter HALT, halted=1, outputs at defaults, PC frozen, exit only via rst_n.
REQ-027 SRM_HALT_EN undefined: opcode 111 SHALL behave as NOP per REQ-022; halted tied 0.
Structure
REQ-028 Package srm_pkg SHALL hold opcode/op constants, state enum, mem_cmd encodings, vsel encodings (C 00, PC 01, SXIMM8 10, MDATA 11).
REQ-029 Sub-module srm_decoder SHALL hold combinational field extraction and sign extension; FSM, PC, IR, data_addr in srm_controller.
Verification
REQ-030 Reset then read_data=16'hD105 (MOV R1,#5) -> WR_IMM writenum=1, vsel=10, sximm8=0005, write=1; PC=01.
REQ-031 IR 16'hA0A1 (ADD R5,R0,R1) -> EXEC anum=0, bnum=1, loadc=1; WB writenum=5, write=1; 6 cycles.
REQ-032 IR 16'hA908 (CMP R1,R0), then 16'hE000 -> loads=1 once, write never; with SRM_HALT_EN halted=1 and mem_cmd NONE thereafter, without it fetch resumes.
REQ-033 LDR R2,[R1,#3] with creg=0008 in ADDR -> mem_addr=08 READ two cycles, vsel=11, writenum=2, write=1 in LD_WB.
REQ-034 STR then rst_n pulsed low in MEM_WR -> mem_cmd NONE immediately, PC=RESET_PC, next fetch from 00.
REQ-035 PC=FF fetch -> PC wraps to 00.
